// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART receiver.
//   rx_state_e        - receive FSM state encoding
//   MIN_DIVIDER       - smallest usable clocks-per-bit value
//   FIFO_DEPTH_MIN/MAX and fifo_depth_legal() - legal receive FIFO sizes
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam logic [15:0] MIN_DIVIDER    = 16'd4;
  localparam int          FIFO_DEPTH_MIN = 2;
  localparam int          FIFO_DEPTH_MAX = 16;

  // Depth must be a power of two so pointers wrap for free.
  function automatic bit fifo_depth_legal(input int depth);
    return (depth >= FIFO_DEPTH_MIN) && (depth <= FIFO_DEPTH_MAX) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO.
//   clock, reset_n : clock and asynchronous active-low reset
//   push, din      : write din when not full (or when full and popping)
//   pop            : advance the head; ignored when empty
//   dout           : current head, 0 when empty
//   full, empty    : status
//   count          : number of valid entries, 0..DEPTH
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == 5'(DEPTH));
  assign empty = (count_q == 5'd0);
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves on the
  // same edge; the write then lands in the slot being vacated.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is forced to 0 while empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a show-ahead receive FIFO.
//   clock, reset_n  : clock and asynchronous active-low reset
//   clock_divider   : clocks per bit (values below 4 act as 4)
//   rx              : asynchronous serial input, idle high
//   read_en         : pop the FIFO head
//   clear_errors    : clear framing_error and overrun
//   data_out        : FIFO head (0 when empty)
//   data_ready      : FIFO not empty
//   framing_error   : sticky, stop bit sampled low
//   overrun         : sticky, byte dropped on a full FIFO
//   fifo_count      : FIFO occupancy
// Read handshake: data_ready is the valid, read_en the ready; a byte is
// consumed on a clock edge where both are high, and read_en alone does nothing.
// The FSM state is visible as state_q for checkers.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] clock_divider,
  input  logic        rx,
  input  logic        read_en,
  input  logic        clear_errors,
  output logic [7:0]  data_out,
  output logic        data_ready,
  output logic        framing_error,
  output logic        overrun,
  output logic [4:0]  fifo_count
);

  if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $error("uart_rx_buffered: FIFO_DEPTH must be a power of two in 2..16");
  end

  rx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        rx_meta_q, rx_s_q;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [15:0] divider_eff;
  logic        expire;
  logic        rx_push;
  logic        fe_set;
  logic        fifo_full;
  logic        fifo_empty;

  assign divider_eff = (clock_divider < MIN_DIVIDER) ? MIN_DIVIDER : clock_divider;
  assign expire      = (timer_q <= 16'd1);

  // After reset the synchronizer holds 1 regardless of the line, so a line
  // that is low across reset release would look like a start bit. Reception
  // is armed only once the settled line has been seen high.
  assign settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  assign armed_d  = armed_q | ((settle_q == 2'd3) & rx_s_q);

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != 16'd0) ? timer_q - 16'd1 : 16'd0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_push   = 1'b0;
    fe_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s_q) begin
          state_d = ST_START;
          timer_d = divider_eff >> 1;
        end
      end
      ST_START: begin
        if (expire) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            timer_d   = divider_eff;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (expire) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = divider_eff;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (expire) begin
          if (rx_s_q) begin
            rx_push = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held break stays here, so it can never be read as more frames.
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set wins over clear. A push into a full FIFO is dropped unless the head
  // is popped on the same edge.
  assign fe_d = fe_set | (fe_q & ~clear_errors);
  assign ov_d = (rx_push & fifo_full & ~read_en) | (ov_q & ~clear_errors);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      timer_q   <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      settle_q  <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (read_en),
    .din     (shift_d),
    .dout    (data_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign data_ready    = ~fifo_empty;
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed self-checking bench for uart_rx_buffered.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] clock_divider;
  logic        rx;
  logic        read_en;
  logic        clear_errors;
  logic [7:0]  data_out;
  logic        data_ready;
  logic        framing_error;
  logic        overrun;
  logic [4:0]  fifo_count;

  always #5 clock = ~clock;

  uart_rx_buffered #(.FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .rx            (rx),
    .read_en       (read_en),
    .clear_errors  (clear_errors),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .fifo_count    (fifo_count)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int bp    = 16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_divider(input logic [15:0] d);
    clock_divider = d;
    bp = (d < 16'd4) ? 4 : int'(d);
  endtask

  task automatic drive_start_and_bits(input logic [7:0] b, input int nbits);
    rx = 1'b0;
    wait_cycles(bp);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      wait_cycles(bp);
    end
  endtask

  // Full frame. ready_at: first stop-bit cycle at which fifo_count changed
  // (-1 if never). With pop_on_push, read_en is raised on the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input bit pop_on_push, output int ready_at);
    logic [4:0] cnt0;
    logic [7:0] head;
    bit         popped;
    ready_at = -1;
    popped   = 0;
    drive_start_and_bits(b, 8);
    cnt0 = fifo_count;
    rx   = stop_val;
    for (int k = 1; k <= bp; k++) begin
      @(negedge clock);
      read_en = 1'b0;
      if (ready_at < 0 && fifo_count != cnt0) ready_at = k;
      if (pop_on_push && !popped && dut.rx_push) begin
        popped = 1;
        head   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("head_at_push", 32'(data_out), 32'(head));
        read_en = 1'b1;
      end
    end
    if (pop_on_push) check("pop_on_push_seen", 32'(popped), 32'd1);
    read_en = 1'b0;
    rx      = 1'b1;
    wait_cycles(4);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    check({tag, "_ready"}, 32'(data_ready), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_data"}, 32'(data_out), 32'(e));
    read_en = 1'b1;
    @(negedge clock);
    read_en = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ra;
    reset_n      = 1'b0;
    rx           = 1'b1;
    read_en      = 1'b0;
    clear_errors = 1'b0;
    set_divider(16'd16);
    wait_cycles(3);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_framing", 32'(framing_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    wait_cycles(10);

    // read on an empty FIFO does nothing
    read_en = 1'b1;
    wait_cycles(1);
    read_en = 1'b0;
    wait_cycles(1);
    check("empty_read_count", 32'(fifo_count), 32'd0);
    check("empty_read_data", 32'(data_out), 32'h0);

    // single good frame 0x55, latency from stop-bit start
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 0, ra);
    check("lat_0x55_in_window", 32'(ra >= 9 && ra <= 12), 32'd1);
    check("count_0x55", 32'(fifo_count), 32'd1);
    read_check("rd_0x55");
    check("count_after_rd", 32'(fifo_count), 32'd0);

    // 5-cycle glitch: no frame, no flags
    rx = 1'b0;
    wait_cycles(5);
    rx = 1'b1;
    wait_cycles(3 * bp);
    check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_fe", 32'(framing_error), 32'd0);
    check("glitch_ov", 32'(overrun), 32'd0);

    // framing error followed by a long break
    send_frame(8'hA3, 1'b0, 0, ra);
    rx = 1'b0;
    wait_cycles(40 * bp);
    check("brk_fe", 32'(framing_error), 32'd1);
    check("brk_count", 32'(fifo_count), 32'd0);
    check("brk_state", 32'(dut.state_q), 32'(ST_WAIT_HIGH));
    rx = 1'b1;
    wait_cycles(2 * bp);
    check("brk_count_after_high", 32'(fifo_count), 32'd0);
    clear_errors = 1'b1;
    wait_cycles(1);
    clear_errors = 1'b0;
    check("fe_cleared", 32'(framing_error), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0, ra);
    read_check("rd_0x3C");

    // overrun: five frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0, ra);
    end
    check("ovr_count", 32'(fifo_count), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    clear_errors = 1'b1;
    wait_cycles(1);
    clear_errors = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // push and pop on the same cycle while full
    exp_q.push_back(8'h06);
    send_frame(8'h06, 1'b1, 1, ra);
    check("pp_count", 32'(fifo_count), 32'd4);
    check("pp_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) read_check("rd_drain");
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_ready", 32'(data_ready), 32'd0);

    // reset in the middle of data bit 4 (bit 4 of 0xA5 is 0)
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0, ra);
    check("pre_rst_count", 32'(fifo_count), 32'd1);
    drive_start_and_bits(8'hA5, 4);
    rx = 1'b0;
    wait_cycles(bp / 2);
    check("pre_rst_state", 32'(dut.state_q), 32'(ST_DATA));
    reset_n = 1'b0;
    exp_q.delete();
    wait_cycles(3);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(data_ready), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    reset_n = 1'b1;
    wait_cycles(3 * bp);
    check("post_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_fe", 32'(framing_error), 32'd0);
    rx = 1'b1;
    wait_cycles(2 * bp);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 0, ra);
    check("count_0x7E", 32'(fifo_count), 32'd1);
    read_check("rd_0x7E");

    // divider below the minimum behaves as 4
    set_divider(16'd2);
    wait_cycles(8);
    exp_q.push_back(8'h9C);
    send_frame(8'h9C, 1'b1, 0, ra);
    read_check("rd_0x9C_min_div");
    check("final_fe", 32'(framing_error), 32'd0);
    check("final_ov", 32'(overrun), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clock, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port clock_divider, input, 16 bits: clock cycles per bit period; values below 4 are treated as 4.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port read_en, input, 1 bit: pops the FIFO head on this cycle.
REQ-007 SHALL have port clear_errors, input, 1 bit: clears the sticky error flags.
REQ-008 SHALL have port data_out, output, 8 bits: FIFO head (show-ahead); 0 when empty.
REQ-009 SHALL have port data_ready, output, 1 bit: FIFO is not empty.
REQ-010 SHALL have port framing_error, output, 1 bit: sticky flag, stop bit sampled low.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, byte dropped because the FIFO was full.
REQ-012 SHALL have port fifo_count, output, 5 bits: number of valid entries.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s), reset to 1; all sampling uses rx_s.
REQ-014 SHALL use the FSM states IDLE, START, DATA, STOP and WAIT_HIGH, with a 16-bit bit-timer and a 3-bit bit index.
REQ-015 IDLE: when rx_s is 0, SHALL load the timer with divider>>1 and go to START.
REQ-016 START: at timer expiry, SHALL go to DATA and load the timer with the full divider if rx_s is 0; otherwise it is a glitch and SHALL go to IDLE with no flag set.
REQ-017 DATA: SHALL sample rx_s at each full-period expiry, LSB first, 8 samples; after bit 7 it SHALL go to STOP.
REQ-018 STOP: at expiry, if rx_s is 1 SHALL push the byte and go to IDLE; if rx_s is 0 SHALL discard the byte, set framing_error and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL stay until rx_s is 1, then go to IDLE; break conditions SHALL never produce repeated frames.
REQ-020 A pushed byte SHALL be visible on data_out with data_ready=1 on the cycle after the stop-bit sample.
REQ-021 read_en with data_ready=1 SHALL advance the head on the next edge; read_en on an empty FIFO SHALL have no effect.
REQ-022 A push while full with no pop SHALL drop the new byte, leave contents unchanged and set overrun.
REQ-023 A push and a pop in the same cycle SHALL both occur: count is unchanged and no overrun is flagged, including when the FIFO is full.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count ranges from 0 to FIFO_DEPTH inclusive.
REQ-025 clear_errors SHALL clear both flags; if a set event coincides with clear_errors, set SHALL win.
REQ-026 clock_divider SHALL be sampled at each timer load; a change mid-frame affects only later loads.

Reset
REQ-027 On reset_n low, SHALL set: FSM to IDLE; timer, index and shift register to 0; FIFO pointers and count to 0; data_out 0; data_ready 0; framing_error 0; overrun 0; synchronizer to 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte; after release, reception restarts only on a fresh falling edge of rx_s.

Structure
REQ-029 Package uart_pkg SHALL hold the rx FSM state encoding, MIN_DIVIDER=4 and the FIFO_DEPTH legality constants.
REQ-030 The FIFO SHALL be a sub-module byte_fifo (show-ahead; push, pop, full, empty, count); the FSM and synchronizer SHALL stay in uart_rx_buffered.

Verification
REQ-031 Divider 16, frame 0x55 with valid stop -> data_out=0x55 and data_ready=1 within 2 cycles of the stop mid-bit; fifo_count=1.
REQ-032 Divider 16, a 5-cycle low pulse on rx -> FSM returns to IDLE, no push, no flags.
REQ-033 Frame 0xA3 with stop bit low, rx held low for 40 bit periods -> framing_error=1, FIFO empty, no extra frames; a following 0x3C is received correctly.
REQ-034 FIFO_DEPTH=4, five frames 0x01..0x05 with no reads -> count=4, overrun=1, reads return 0x01..0x04; clear_errors sets overrun to 0.
REQ-035 FIFO full, read_en asserted on the push cycle of 0x06 -> count stays 4, overrun=0, the tail holds 0x06.
REQ-036 reset_n pulsed low during data bit 4 -> all outputs return to reset values; the next complete frame 0x7E is received intact.
